// File: rtl/mempool_pkg.sv
// Shared types for the MemPool TCDM bank path: data/strobe types and the
// response record carried from a bank back to its requesters.
package mempool_pkg;

    // Default bank geometry; the arbiter's parameters default to these values,
    // so overriding them on an instance must be mirrored here.
    localparam int unsigned BankNumReq    = 4;
    localparam int unsigned BankDataWidth = 32;
    localparam int unsigned BankIdxWidth  = $clog2(BankNumReq);

    typedef logic [BankDataWidth-1:0]   data_t;
    typedef logic [BankDataWidth/8-1:0] strb_t;

    // A read response: the requester that issued the read plus its data.
    typedef struct packed {
        logic [BankIdxWidth-1:0] idx;
        data_t                   rdata;
    } bank_resp_t;

endpackage

// File: rtl/fifo_v3.sv
// Small FIFO with the common_cells fifo_v3 interface shape, using the bank's
// active-high asynchronous reset. With FALL_THROUGH set, a push into an empty
// queue is visible on data_o in the same cycle and can be popped right away
// without ever being stored.
module fifo_v3 #(
    parameter bit          FALL_THROUGH = 1'b0,
    parameter int unsigned DEPTH        = 8,
    parameter type         dtype        = logic,
    localparam int unsigned AddrDepth   = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
    input  logic             clk_i,
    input  logic             rst_i,
    output logic             full_o,
    output logic             empty_o,
    output logic [AddrDepth:0] usage_o,
    input  dtype             data_i,
    input  logic             push_i,
    output dtype             data_o,
    input  logic             pop_i
);

    localparam logic [AddrDepth-1:0] LastPtr   = AddrDepth'(DEPTH - 1);
    localparam logic [AddrDepth:0]   FullCount = (AddrDepth + 1)'(DEPTH);

    logic [AddrDepth-1:0] rdPtr_q, rdPtr_d;
    logic [AddrDepth-1:0] wrPtr_q, wrPtr_d;
    logic [AddrDepth:0]   count_q, count_d;
    logic                 memWe;
    dtype                 mem_q [DEPTH];

    assign full_o  = (count_q == FullCount);
    assign empty_o = (count_q == '0) & ~(FALL_THROUGH & push_i);
    assign usage_o = count_q;

    // Pointer/count bookkeeping; a bypassed push-and-pop leaves storage untouched.
    always_comb begin
        rdPtr_d = rdPtr_q;
        wrPtr_d = wrPtr_q;
        count_d = count_q;
        memWe   = 1'b0;
        data_o  = mem_q[rdPtr_q];
        if (push_i && !full_o) begin
            memWe   = 1'b1;
            wrPtr_d = (wrPtr_q == LastPtr) ? '0 : wrPtr_q + 1'b1;
            count_d = count_q + 1'b1;
        end
        if (pop_i && (count_q != '0)) begin
            rdPtr_d = (rdPtr_q == LastPtr) ? '0 : rdPtr_q + 1'b1;
            count_d = count_d - 1'b1;
        end
        if (FALL_THROUGH && (count_q == '0) && push_i) begin
            data_o = data_i;
            if (pop_i) begin
                memWe   = 1'b0;
                wrPtr_d = wrPtr_q;
                count_d = count_q;
            end
        end
    end

    // Storage and pointer registers.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            rdPtr_q <= '0;
            wrPtr_q <= '0;
            count_q <= '0;
            mem_q   <= '{default: '0};
        end else begin
            rdPtr_q <= rdPtr_d;
            wrPtr_q <= wrPtr_d;
            count_q <= count_d;
            if (memWe) begin
                mem_q[wrPtr_q] <= data_i;
            end
        end
    end

endmodule

// File: rtl/tcdm_bank_arbiter.sv
// Round-robin arbiter in front of one single-ported TCDM bank. Grants one
// request per cycle, drives the bank, and returns read data through a small
// fall-through response queue so requesters can backpressure responses.
// Optional build macro MEMPOOL_BANK_ARB_PERF_EN adds a saturating 32-bit
// conflict counter output (conflict_cnt_o).
module tcdm_bank_arbiter
    import mempool_pkg::*;
#(
    parameter int unsigned NumReq       = BankNumReq,
    parameter int unsigned DataWidth    = BankDataWidth,
    parameter int unsigned AddrMemWidth = 8,
    parameter int unsigned RespDepth    = 2,
    localparam int unsigned IdxWidth    = $clog2(NumReq)
) (
    input  logic                                    clk_i,
    input  logic                                    rst_i,
    input  logic [NumReq-1:0]                       req_valid_i,
    output logic [NumReq-1:0]                       req_ready_o,
    input  logic [NumReq-1:0][AddrMemWidth-1:0]     req_addr_i,
    input  logic [NumReq-1:0]                       req_wen_i,
    input  logic [NumReq-1:0][DataWidth-1:0]        req_wdata_i,
    input  logic [NumReq-1:0][DataWidth/8-1:0]      req_be_i,
    output logic                                    bank_req_o,
    output logic [AddrMemWidth-1:0]                 bank_addr_o,
    output logic                                    bank_wen_o,
    output logic [DataWidth-1:0]                    bank_wdata_o,
    output logic [DataWidth/8-1:0]                  bank_be_o,
    input  logic [DataWidth-1:0]                    bank_rdata_i,
    output logic                                    resp_valid_o,
    input  logic                                    resp_ready_i,
    output logic [IdxWidth-1:0]                     resp_idx_o,
    output logic [DataWidth-1:0]                    resp_rdata_o
`ifdef MEMPOOL_BANK_ARB_PERF_EN
    ,
    output logic [31:0]                             conflict_cnt_o
`endif
);

    localparam int unsigned CntWidth = ((RespDepth > 1) ? $clog2(RespDepth) : 1) + 1;

    logic [IdxWidth-1:0] ptr_q, ptr_d;
    logic                inflight_q, inflight_d;
    logic [IdxWidth-1:0] inflightIdx_q, inflightIdx_d;

    logic [CntWidth-1:0] respUsage;
    logic                respFull;
    logic                respEmpty;
    logic                respPop;
    bank_resp_t          pushData;
    bank_resp_t          popData;

    logic                readCredit;
    logic [NumReq-1:0]   eligible;
    logic                grantValid;
    logic [IdxWidth-1:0] grantIdx;
    logic [IdxWidth-1:0] candIdx;
    int unsigned         cand;

    // A read may only be granted if its response is guaranteed a queue slot,
    // counting the read still in the SRAM pipeline; same-cycle pops are ignored.
    always_comb begin
        readCredit = !respFull && ((32'(respUsage) + 32'(inflight_q)) < RespDepth);
        eligible   = req_valid_i & (req_wen_i | {NumReq{readCredit}});
    end

    // Round-robin search over the eligible set starting at the priority pointer.
    always_comb begin
        grantValid = 1'b0;
        grantIdx   = '0;
        cand       = 0;
        candIdx    = '0;
        for (int k = 0; k < NumReq; k++) begin
            cand = 32'(ptr_q) + 32'(k);
            if (cand >= NumReq) begin
                cand = cand - NumReq;
            end
            candIdx = IdxWidth'(cand);
            if (!grantValid && !rst_i && eligible[candIdx]) begin
                grantValid = 1'b1;
                grantIdx   = candIdx;
            end
        end
    end

    // Drive the grant and the bank port from the winner; everything idles at 0.
    always_comb begin
        req_ready_o   = '0;
        bank_req_o    = 1'b0;
        bank_addr_o   = '0;
        bank_wen_o    = 1'b0;
        bank_wdata_o  = '0;
        bank_be_o     = '0;
        ptr_d         = ptr_q;
        inflight_d    = 1'b0;
        inflightIdx_d = inflightIdx_q;
        if (grantValid) begin
            req_ready_o[grantIdx] = 1'b1;
            bank_req_o    = 1'b1;
            bank_addr_o   = req_addr_i[grantIdx];
            bank_wen_o    = req_wen_i[grantIdx];
            bank_wdata_o  = req_wdata_i[grantIdx];
            bank_be_o     = req_be_i[grantIdx];
            ptr_d         = (grantIdx == IdxWidth'(NumReq - 1)) ? '0 : grantIdx + 1'b1;
            inflight_d    = ~req_wen_i[grantIdx];
            inflightIdx_d = grantIdx;
        end
    end

    // Priority pointer and the one-deep record of the read in the SRAM pipeline.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            ptr_q         <= '0;
            inflight_q    <= 1'b0;
            inflightIdx_q <= '0;
        end else begin
            ptr_q         <= ptr_d;
            inflight_q    <= inflight_d;
            inflightIdx_q <= inflightIdx_d;
        end
    end

    // The returning read is pushed the cycle after its grant, tagged with its requester.
    always_comb begin
        pushData.idx   = inflightIdx_q;
        pushData.rdata = bank_rdata_i;
        respPop        = resp_valid_o & resp_ready_i;
    end

    fifo_v3 #(
        .FALL_THROUGH (1'b1),
        .DEPTH        (RespDepth),
        .dtype        (bank_resp_t)
    ) i_resp_fifo (
        .clk_i   (clk_i),
        .rst_i   (rst_i),
        .full_o  (respFull),
        .empty_o (respEmpty),
        .usage_o (respUsage),
        .data_i  (pushData),
        .push_i  (inflight_q),
        .data_o  (popData),
        .pop_i   (respPop)
    );

    assign resp_valid_o = ~respEmpty;
    assign resp_idx_o   = popData.idx;
    assign resp_rdata_o = popData.rdata;

`ifdef MEMPOOL_BANK_ARB_PERF_EN
    logic [31:0] conflictCnt_q;

    // Count cycles where some valid request was left waiting; saturate at all-ones.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            conflictCnt_q <= '0;
        end else if ((|(req_valid_i & ~req_ready_o)) && (conflictCnt_q != 32'hFFFF_FFFF)) begin
            conflictCnt_q <= conflictCnt_q + 32'd1;
        end
    end

    assign conflict_cnt_o = conflictCnt_q;
`endif

endmodule

// File: doc/tcdm_bank_arbiter.md
# tcdm_bank_arbiter

Shares one single-ported TCDM SRAM bank among `NumReq` local requesters, such as the cores of a tile plus the remote-port slot from the interconnect. It grants one request per cycle in round-robin order and drives the bank. It tracks the return index of each read through the 1-cycle SRAM latency and queues read responses so requesters can apply backpressure. It sits between a tile's request crossbar and each bank instance.

## Interface
- `NumReq`, 4: number of requesters, ≥2.
- `DataWidth`, 32: data width in bits.
- `AddrMemWidth`, 8: bank word-address width.
- `RespDepth`, 2: response queue depth, ≥1.
- `IdxWidth`, `$clog2(NumReq)`: dependent, do not override.

Ports:
- `clk_i` in 1: clock.
- `rst_i` in 1: reset, asynchronous, active-high.
- `req_valid_i` in `NumReq`: request valid, one bit per requester.
- `req_ready_o` out `NumReq`: grant, at most one bit high.
- `req_addr_i` in `NumReq×AddrMemWidth`: word address.
- `req_wen_i` in `NumReq`: 1 = write.
- `req_wdata_i` in `NumReq×DataWidth`: write data.
- `req_be_i` in `NumReq×DataWidth/8`: byte enables.
- `bank_req_o` out 1: bank access strobe.
- `bank_addr_o` out `AddrMemWidth`, `bank_wen_o` out 1, `bank_wdata_o` out `DataWidth`, `bank_be_o` out `DataWidth/8`: bank access fields.
- `bank_rdata_i` in `DataWidth`: read data, valid the cycle after a read strobe.
- `resp_valid_o` out 1, `resp_ready_i` in 1: response handshake.
- `resp_idx_o` out `IdxWidth`: index of the requester that issued the read.
- `resp_rdata_o` out `DataWidth`: read data.

## Operation
- **Arbitration:** round-robin with priority pointer `ptr`. Among eligible valid requesters, grant the first at or after `ptr`, modulo `NumReq`.
  - After a grant to requester i, `ptr` ← (i+1) mod `NumReq`. The pointer wraps from `NumReq-1` to 0.
  - `ptr` is unchanged in cycles with no grant.
- **Eligibility:**
  - A write is always eligible.
  - A read is eligible only if `occ + inflight < RespDepth`. `occ` is the queue occupancy; `inflight` is a 1-bit flag set when a read was granted in the previous cycle.
  - A pop in the same cycle is not credited. This is conservative, and the queue never overflows.
- **Bank drive:** when a grant occurs, `bank_req_o`=1 and the bank fields are muxed from the granted requester. When there is no grant, all bank outputs are 0.
- **Writes** produce no response.
- **Read return:** a read granted in cycle T pushes {idx, `bank_rdata_i`} into the response queue in cycle T+1.
- **Response queue:** FIFO in fall-through mode.
  - If the queue is empty in T+1, `resp_valid_o`, `resp_idx_o` and `resp_rdata_o` show the returning read combinationally in T+1.
  - An entry pops when `resp_valid_o & resp_ready_i`.
  - Responses are delivered strictly in grant order.
- **Queue full:** all reads stall; writes continue to be granted.
- **Simultaneous push and pop:** occupancy is unchanged; data order is preserved.
- **Reset (asynchronous):**
  - `ptr`=0, queue empty, `inflight`=0.
  - All outputs read 0: `req_ready_o`, `bank_*`, `resp_*`.
  - A read in flight when reset asserts is discarded and never produces a response.

## Timing
- Request to grant: 0 cycles. `req_ready_o` is combinational from `req_valid_i`, `req_wen_i`, `ptr` and the queue state.
- Grant to bank strobe: same cycle.
- Read grant to response valid: 1 cycle minimum when the queue is empty, plus queueing delay.
- Throughput: 1 access per cycle. Reads sustain one per cycle when `RespDepth`≥2 and `resp_ready_i`=1.
- There is no combinational path from `resp_ready_i` to `req_ready_o`.
- Requesters must hold `req_*` stable while `req_valid_i`=1 and `req_ready_o`=0.

## Configuration
- Macro `MEMPOOL_BANK_ARB_PERF_EN`.
- **Defined:** adds output `conflict_cnt_o`, 32 bits.
  - It counts cycles in which at least one `req_valid_i` bit was set but not granted, whether due to arbitration loss or queue stall.
  - The counter saturates at 32'hFFFF_FFFF and resets to 0.
- **Undefined:** the port and counter logic are absent; functionality is otherwise identical.

## Structure
- `mempool_pkg` holds `data_t`, `strb_t`, and a shared `bank_resp_t` struct {idx, rdata}; `IdxWidth` remains a local parameter.
- One sub-module is used: common_cells `fifo_v3`, FALL_THROUGH=1, DEPTH=`RespDepth`, dtype `bank_resp_t`.
- Arbitration stays inline because eligibility masking precedes the round-robin search.

## Test plan
- **Round-robin, writes:** all four requesters present writes continuously → grants 0,1,2,3,0 on consecutive cycles, `bank_req_o`=1 every cycle, `resp_valid_o` never set.
- **Single read:** requester 2 reads addr 0x05 at T, bank returns 0xDEADBEEF at T+1 → at T+1 `resp_valid_o`=1, `resp_idx_o`=2, `resp_rdata_o`=0xDEADBEEF.
- **Backpressure, mixed:** `resp_ready_i`=0, `RespDepth`=2, requester 0 issues reads every cycle → exactly 2 reads granted, then `req_ready_o[0]`=0.
  - A concurrent write from requester 1 is still granted.
  - Raising `resp_ready_i` drains the responses in order.
- **Pointer wrap:** grant requester 3, then only requesters 0 and 3 valid → requester 0 granted next.
- **Reset mid-read:** assert `rst_i` in the cycle after a read grant → no response ever appears, all outputs 0, and the first post-reset grant goes to the lowest valid index.
- **Perf counter (`MEMPOOL_BANK_ARB_PERF_EN`):** 3 requesters valid for 10 cycles → `conflict_cnt_o`=10. A forced value near the limit saturates at 32'hFFFF_FFFF.
